imem_loader: RTL and testbench

Byte-stream program loader that writes the instruction memory before the CPU starts. It accepts a framed byte stream, typically from the UART receiver, over a valid/ready handshake. It packs big-endian 32-bit instruction words and issues single-cycle writes into the instruction memory array at word addresses 0..N-1. It holds the CPU in reset until a complete, valid image has been written.

---
 rtl/imem_loader_if.sv | 29 ++
 rtl/imem_loader.sv | 177 +++++++++++++++++
 tb/tb_imem_loader.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Byte-stream handshake and instruction-memory write port bundle.
// Revision : 1.0
// ============================================================================
interface imem_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // slave: the loader side (consumes the stream, drives memory writes)
  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  // master: the environment side (byte source and memory sink)
  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Framed byte-stream loader writing big-endian words into imem;
//            holds the CPU in reset until a complete image is written.
//            Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module imem_loader #(
  parameter int unsigned ADDR_W = 10,
  parameter logic [7:0]  MAGIC  = 8'hA5
) (
  input  logic            clk,
  input  logic            rst,
  imem_loader_if.slave    bus,
  output logic            cpu_rst,
  output logic            done,
  output logic            error
);

  localparam int unsigned   LEN_W  = ADDR_W + 1;
  localparam logic [31:0]   C_CAP  = 32'd1 << ADDR_W;
  localparam logic [LEN_W-1:0] C_ONE = LEN_W'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK    = 3'd4;
`endif
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]        state_q,     state_d;
  logic [7:0]        len_hi_q,    len_hi_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  logic [LEN_W-1:0]  word_cnt_q,  word_cnt_d;
  logic [1:0]        byte_cnt_q,  byte_cnt_d;
  // Only the three most recent bytes need keeping; the fourth arrives live.
  logic [23:0]       shift_q,     shift_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              in_ready_q,  in_ready_d;
  logic              done_q,      done_d;
  logic              error_q,     error_d;
  logic              cpu_rst_q,   cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q,      csum_d;
`endif

  logic        w_fire;
  logic [15:0] w_len_raw;
  logic [31:0] w_word_next;
  logic        w_last_word;

  assign w_fire      = bus.in_valid && in_ready_q;
  assign w_len_raw   = {len_hi_q, bus.in_data};
  assign w_word_next = {shift_q, bus.in_data};
  assign w_last_word = (word_cnt_q + C_ONE) == len_q;

  always_comb begin
    state_d     = state_q;
    len_hi_d    = len_hi_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    if (w_fire) begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_data == MAGIC) state_d = S_LEN_HI;
        end
        S_LEN_HI: begin
          len_hi_d = bus.in_data;
          state_d  = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d      = LEN_W'(w_len_raw);
          word_cnt_d = '0;
          byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
          if (w_len_raw == 16'd0 || 32'(w_len_raw) > C_CAP) state_d = S_ERR;
          else                                              state_d = S_DATA;
        end
        S_DATA: begin
          shift_d    = w_word_next[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ bus.in_data;
`endif
          if (byte_cnt_q == 2'd3) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = word_cnt_q[ADDR_W-1:0];
            mem_wdata_d = w_word_next;
            word_cnt_d  = word_cnt_q + C_ONE;
            if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = S_CHK;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
        end
`endif
        default: ;
      endcase
    end
    // Status outputs are registered images of the next state.
    in_ready_d = !(state_d == S_DONE || state_d == S_ERR);
    done_d     = (state_d == S_DONE);
    error_d    = (state_d == S_ERR);
    cpu_rst_d  = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_hi_q    <= '0;
      len_q       <= '0;
      word_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      in_ready_q  <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_rst_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      len_hi_q    <= len_hi_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      in_ready_q  <= in_ready_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_rst_q   <= cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_rst       = cpu_rst_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Scoreboard bench for imem_loader: expected writes are queued as
//            frames are sent; a monitor pops them whenever mem_we is seen.
// Revision : 1.0
// ============================================================================
module tb_imem_loader;
  localparam int unsigned ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_rst, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  wr_t         exp_q[$];
  wr_t         mon_e;
  logic [31:0] frame_words[$];
  bit          stall_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual addr=%0d data=0x%08h required=no write", bus.mem_addr, bus.mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.mem_addr), 32'(mon_e.addr));
        check("wr_data", bus.mem_wdata, mon_e.data);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Caller is at a negedge; the byte is transferred on the following posedge.
  task automatic send_byte(input logic [7:0] b);
    if (stall_en) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    check("in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Sends MAGIC, LEN and frame_words; checksum byte (if built in) is XOR ^ csum_xor.
  task automatic send_frame(input logic [15:0] len, input logic [7:0] csum_xor);
    logic [7:0]  cs;
    logic [31:0] w;
    wr_t         e;
    cs = 8'h00;
    send_byte(8'hA5);
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    for (int i = 0; i < frame_words.size(); i++) begin
      w      = frame_words[i];
      e.addr = ADDR_W'(i);
      e.data = w;
      exp_q.push_back(e);
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cs ^ csum_xor);
`else
    if (csum_xor != 8'h00) cs = 8'h00;
`endif
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd1);
    check("rst_mem_we",    {31'd0, bus.mem_we},   32'd0);
    check("rst_mem_addr",  32'(bus.mem_addr),     32'd0);
    check("rst_mem_wdata", bus.mem_wdata,         32'd0);
    check("rst_cpu_rst",   {31'd0, cpu_rst},      32'd1);
    check("rst_done",      {31'd0, done},         32'd0);
    check("rst_error",     {31'd0, error},        32'd0);
    rst = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic c);
    check({tag, "_done"},    {31'd0, done},    {31'd0, d});
    check({tag, "_error"},   {31'd0, error},   {31'd0, e});
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, {31'd0, c});
  endtask

  initial begin
    wr_t e;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Basic load at one byte per cycle
    do_reset();
    frame_words = '{32'h12345678, 32'h9ABCDEF0};
    send_frame(16'd2, 8'h00);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("basic_we_with_done", {31'd0, bus.mem_we}, 32'd1);
`endif
    check_status("basic", 1'b1, 1'b0, 1'b0);
    idle();
    check("basic_ready_low", {31'd0, bus.in_ready}, 32'd0);
    bus.in_data  = 8'hA5;
    bus.in_valid = 1'b1;
    repeat (4) @(negedge clk);
    idle();
    check_status("basic_after", 1'b1, 1'b0, 1'b0);
    check("basic_pending", 32'(exp_q.size()), 32'd0);

    // Junk bytes ahead of the frame
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_frame(16'd2, 8'h00);
    check_status("junk", 1'b1, 1'b0, 1'b0);
    idle();
    check("junk_pending", 32'(exp_q.size()), 32'd0);

    // LEN == 0
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h00);
    check("len0_err_early", {31'd0, error}, 32'd0);
    send_byte(8'h00);
    check_status("len0", 1'b0, 1'b1, 1'b1);
    idle();
    check("len0_ready_low", {31'd0, bus.in_ready}, 32'd0);

    // LEN == 1025 exceeds capacity
    do_reset();
    send_byte(8'hA5);
    send_byte(8'h04);
    send_byte(8'h01);
    check_status("len1025", 1'b0, 1'b1, 1'b1);
    idle();
    check("len1025_ready_low", {31'd0, bus.in_ready}, 32'd0);

    // Full capacity with random source stalls
    do_reset();
    frame_words.delete();
    for (int i = 0; i < 1024; i++) frame_words.push_back(32'(i) * 32'h9E3779B1 + 32'h01020304);
    stall_en = 1'b1;
    send_frame(16'd1024, 8'h00);
    stall_en = 1'b0;
    check_status("full", 1'b1, 1'b0, 1'b0);
    idle();
    check("full_pending", 32'(exp_q.size()), 32'd0);

    // Reset after six payload bytes, then a clean one-word frame
    do_reset();
    e.addr = '0;
    e.data = 32'h12345678;
    exp_q.push_back(e);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    send_byte(8'h9A);
    send_byte(8'hBC);
    do_reset();
    check("mid_pending", 32'(exp_q.size()), 32'd0);
    frame_words = '{32'h0000000C};
    send_frame(16'd1, 8'h00);
    check_status("mid", 1'b1, 1'b0, 1'b0);
    idle();
    check("mid_pending2", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum mismatch: basic payload XOR is 0x00, so 0x09 is wrong
    do_reset();
    frame_words = '{32'h12345678, 32'h9ABCDEF0};
    send_frame(16'd2, 8'h09);
    check_status("csum_bad", 1'b0, 1'b1, 1'b1);
    idle();
    check("csum_bad_pending", 32'(exp_q.size()), 32'd0);
`endif

    repeat (2) idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
